pll_reset_seq: RTL and testbench

Reset sequencer between the ice40 PLL and the PipelineC-generated top. Synchronizes the PLL `locked` flag into the PLL output clock domain and requires it to stay stable before releasing a clean, glitch-free, synchronous-deassert reset to downstream logic. Re-asserts reset on lock loss or on a software request. Optionally counts lock-loss events for debug.

---
 rtl/pll_reset_seq.sv | 153 +++++++++++++++
 tb/tb_pll_reset_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//
// Reset sequencer between the ice40 PLL and the downstream PipelineC top.
// Brings the asynchronous PLL `locked` flag into the PLL clock domain and
// waits for it to stay high for LOCK_STABLE_CYCLES. It then holds reset for
// RESET_HOLD_CYCLES more cycles before releasing a registered, glitch-free
// reset. Reset is re-asserted on loss of lock or on a software request.
//
// Optional feature macro: PLL_RESET_SEQ_LOSS_COUNT_EN
//   defined   -> 8-bit saturating lock-loss counter is built
//   undefined -> lock_loss_count is tied to 8'h00 and no counter flops exist
//
// Ports:
//   clk             in   PLL output clock
//   rst             in   asynchronous active-high reset of this block
//   locked          in   PLL lock flag, asynchronous to clk
//   sw_rst_req      in   single-cycle request to re-issue downstream reset
//   rst_out         out  active-high downstream reset (registered)
//   ready           out  high while in RUN with rst_out low (registered)
//   state           out  current state: 0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN
//   lock_loss_count out  saturating count of lock losses seen in RUN
// -----------------------------------------------------------------------------
module pll_reset_seq #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       sw_rst_req,
    output logic       rst_out,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic sync_p0;
    logic sync_p1;
    logic locked_s;

    // Synchronizer stage: locked -> sync_p0 -> sync_p1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= locked;
            sync_p1 <= sync_p0;
        end
    end

    assign locked_s = sync_p1;

    // Lock loss is tested first in every state so it always wins over
    // sw_rst_req; sw_rst_req is only looked at in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = STABLE_LOAD;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (sw_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // State register stage: outputs are decoded from the next state so they
    // switch on the same edge as `state`.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            rst_out <= 1'b1;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_out <= (state_d != RUN);
            ready   <= (state_d == RUN);
        end
    end

    assign state = state_q;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q;

    // Lock-loss counter stage: counts RUN -> WAIT_LOCK transitions, sticks at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt_q <= 8'h00;
        end else if ((state_q == RUN) && !locked_s && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = 8'h00;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
module tb_pll_reset_seq;

    localparam int L = 4;
    localparam int H = 8;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       locked;
    logic       sw_rst_req;
    logic       rst_out;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_count;

    pll_reset_seq #(
        .LOCK_STABLE_CYCLES(L),
        .RESET_HOLD_CYCLES (H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .locked         (locked),
        .sw_rst_req     (sw_rst_req),
        .rst_out        (rst_out),
        .ready          (ready),
        .state          (state),
        .lock_loss_count(lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       rdy;
        logic [1:0] st;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: works on timestamps. Once the synchronized lock
    // is seen at edge n, release is scheduled for edge n+L+H; a software
    // request in RUN at edge n reschedules release for n+H; any cycle
    // with the synchronized lock low cancels the schedule.
    // ---------------------------------------------------------------
    initial begin
        int   n;
        int   rel;
        bit   have_rel;
        bit   was_run;
        bit   ls;
        int   loss_m;
        bit   hist[$];
        exp_t e;
        n        = 0;
        rel      = 0;
        have_rel = 1'b0;
        loss_m   = 0;
        hist     = {1'b0, 1'b0};
        forever begin
            @(posedge clk);
            n++;
            if (rst) begin
                have_rel = 1'b0;
                loss_m   = 0;
                hist     = {1'b0, 1'b0};
                e.r = 1'b1; e.rdy = 1'b0; e.st = 2'd0; e.cnt = 8'd0;
            end else begin
                ls = hist.pop_front();
                hist.push_back(locked);
                was_run = have_rel && (n - 1 >= rel);
                if (!ls) begin
                    if (was_run && loss_m < 255) loss_m++;
                    have_rel = 1'b0;
                end else if (!have_rel) begin
                    rel      = n + L + H;
                    have_rel = 1'b1;
                end else if (was_run && sw_rst_req) begin
                    rel = n + H;
                end
                if (!have_rel)        e.st = 2'd0;
                else if (n < rel - H) e.st = 2'd1;
                else if (n < rel)     e.st = 2'd2;
                else                  e.st = 2'd3;
                e.r   = (e.st != 2'd3);
                e.rdy = (e.st == 2'd3);
                e.cnt = CNT_EN ? 8'(loss_m) : 8'd0;
            end
            sb.push_back(e);
        end
    end

    // Monitor: compares DUT outputs on the falling edge against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rst_out", int'(rst_out), int'(e.r));
                check("ready", int'(ready), int'(e.rdy));
                check("state", int'(state), int'(e.st));
                check("lock_loss_count", int'(lock_loss_count), int'(e.cnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_sw();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        locked     = 1'b0;
        sw_rst_req = 1'b0;

        // Power-up: reset for three edges, then no lock for 50 cycles
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (50) tick();

        // Clean lock and release
        locked = 1'b1;
        repeat (20) tick();

        // Software request in RUN, then a second one during HOLD
        pulse_sw();
        repeat (3) tick();
        pulse_sw();
        repeat (14) tick();

        // Lock loss, then glitchy re-lock
        locked = 1'b0;
        repeat (5) tick();
        locked = 1'b1;
        repeat (3) tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        repeat (20) tick();

        // Software request on the same edge the lock loss reaches the FSM
        locked = 1'b0;
        tick();
        tick();
        pulse_sw();
        repeat (4) tick();
        locked = 1'b1;
        repeat (20) tick();

        // Asynchronous reset mid-HOLD
        pulse_sw();
        repeat (2) tick();
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("async_rst_out", int'(rst_out), 1);
        check("async_ready", int'(ready), 0);
        check("async_state", int'(state), 0);
        check("async_count", int'(lock_loss_count), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();

        // Repeated lock loss to saturate the counter
        for (int i = 0; i < 260; i++) begin
            locked = 1'b0;
            repeat ($urandom_range(3, 6)) tick();
            locked = 1'b1;
            repeat (14 + $urandom_range(1, 4)) tick();
        end
        check("loss_count_saturated", int'(lock_loss_count), CNT_EN ? 255 : 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if (locked) begin
                if ($urandom_range(0, 39) == 0) locked = 1'b0;
            end else begin
                if ($urandom_range(0, 2) == 0) locked = 1'b1;
            end
            if (!sw_rst_req && $urandom_range(0, 14) == 0) sw_rst_req = 1'b1;
            else sw_rst_req = 1'b0;
            tick();
        end
        sw_rst_req = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
